// File: rtl/startup_pkg.sv
// Shared types and default constants for the gate start-up sequencer.
package startup_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_ENABLE,
        ST_WAIT_SYNC,
        ST_SETTLE,
        ST_DONE
    } state_t;

    localparam int DEF_GATE_NUM   = 5;
    localparam int DEF_INIT_DELAY = 1024;
    localparam int DEF_STEP_DELAY = 100000;
    localparam int DEF_TIMEOUT    = 1000000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // The timer is loaded with delay-1, so it only needs to hold max_delay-1.
    function automatic int cnt_width(input int max_delay);
        return (max_delay < 2) ? 1 : $clog2(max_delay);
    endfunction

    // A delay of 0 is treated the same as a delay of 1.
    function automatic int load_val(input int delay);
        return (delay <= 1) ? 0 : delay - 1;
    endfunction

endpackage

// File: rtl/startup_timer.sv
// Loadable down-counter: after a load of N it raises done for one cycle N+1 cycles later.
module startup_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             busy_o,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt;
    logic             run;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (load_i) begin
            cnt <= load_val_i;
            run <= 1'b1;
        end else if (run) begin
            if (cnt == '0) begin
                run <= 1'b0;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign busy_o = run;
    assign done_o = run && (cnt == '0);

endmodule

// File: rtl/startup.sv
// Sequential gate enabler: raises gate enables one at a time, waiting for each gate's sync and a settle delay.
// Optional macro STARTUP_TIMEOUT_EN adds a WAIT_SYNC timeout that restarts the whole sequence.
module startup
    import startup_pkg::*;
#(
    parameter int GATE_NUM   = DEF_GATE_NUM,
    parameter int INIT_DELAY = DEF_INIT_DELAY,
    parameter int STEP_DELAY = DEF_STEP_DELAY,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [GATE_NUM-1:0] gate_sync_i,
    output logic [GATE_NUM-1:0] gate_en_o
);

    localparam int MAX_DELAY = max3(INIT_DELAY, STEP_DELAY, TIMEOUT);
    localparam int CNT_W     = cnt_width(MAX_DELAY);
    localparam int IDX_W     = (GATE_NUM < 2) ? 1 : $clog2(GATE_NUM);

    localparam logic [CNT_W-1:0] INIT_LOAD = CNT_W'(load_val(INIT_DELAY));
    localparam logic [CNT_W-1:0] STEP_LOAD = CNT_W'(load_val(STEP_DELAY));
`ifdef STARTUP_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TOUT_LOAD = CNT_W'(load_val(TIMEOUT));
`endif
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(GATE_NUM - 1);

    logic [GATE_NUM-1:0] sync_p0, sync_p1;
    state_t              state, state_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic [GATE_NUM-1:0] en_nxt;
    logic                tmr_load, tmr_busy, tmr_done;
    logic [CNT_W-1:0]    tmr_val;

    // Stage p0/p1: two-flop synchronizer for the asynchronous sync feedback
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= gate_sync_i;
            sync_p1 <= sync_p0;
        end
    end

    startup_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .busy_o     (tmr_busy),
        .done_o     (tmr_done)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state     <= ST_INIT;
            idx       <= '0;
            gate_en_o <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            gate_en_o <= en_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        en_nxt    = gate_en_o;
        tmr_load  = 1'b0;
        tmr_val   = INIT_LOAD;
        case (state)
            ST_INIT: begin
                // An idle timer on entry means the initial delay has not been started yet.
                if (!tmr_busy) begin
                    tmr_load = 1'b1;
                    tmr_val  = INIT_LOAD;
                end else if (tmr_done) begin
                    idx_nxt   = '0;
                    state_nxt = ST_ENABLE;
                end
            end
            ST_ENABLE: begin
                en_nxt[idx] = 1'b1;
                state_nxt   = ST_WAIT_SYNC;
`ifdef STARTUP_TIMEOUT_EN
                tmr_load = 1'b1;
                tmr_val  = TOUT_LOAD;
`endif
            end
            ST_WAIT_SYNC: begin
                if (sync_p1[idx]) begin
                    tmr_load  = 1'b1;
                    tmr_val   = STEP_LOAD;
                    state_nxt = ST_SETTLE;
                end
`ifdef STARTUP_TIMEOUT_EN
                else if (tmr_done) begin
                    en_nxt    = '0;
                    state_nxt = ST_INIT;
                end
`endif
            end
            ST_SETTLE: begin
                if (tmr_done) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = ST_DONE;
                    end else begin
                        idx_nxt   = idx + IDX_W'(1);
                        state_nxt = ST_ENABLE;
                    end
                end
            end
            ST_DONE: begin
                en_nxt = '1;
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_startup.sv
// Scoreboard bench for startup: stimulus queues timed expectations, a negedge monitor checks them and flags any unexpected change.
module tb_startup;

    localparam int GN = 5;
    localparam int ID = 8;
    localparam int SD = 4;
    localparam int TO = 32;
    // Loopback: enable edge -> loop reg -> two sync flops -> SETTLE load -> SD -> ENABLE cycle.
    localparam int LOOP_STEP = SD + 5;
    // Sync already high when WAIT_SYNC is entered: one WAIT cycle, SD settle, one ENABLE cycle.
    localparam int FAST_STEP = SD + 2;

    typedef struct {
        int          cyc;
        logic [GN-1:0] val;
        string       name;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [GN-1:0] gate_sync, gate_en, loop_q, sync_drv;
    logic          loop_mode;
    int            cyc = 0;
    int            vectors = 0;
    int            miscompares = 0;
    bit            mon_on = 1'b0;
    logic [GN-1:0] prev;
    exp_t          exp_q[$];
    exp_t          e;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        loop_q <= gate_en;
    end

    assign gate_sync = loop_mode ? loop_q : sync_drv;

    startup #(
        .GATE_NUM   (GN),
        .INIT_DELAY (ID),
        .STEP_DELAY (SD),
        .TIMEOUT    (TO)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .gate_sync_i (gate_sync),
        .gate_en_o   (gate_en)
    );

    always @(negedge clk) begin
        if (mon_on) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                vectors++;
                if (gate_en !== e.val) begin
                    miscompares++;
                    $display("FAIL %s @cycle %0d: gate_en_o=%b expected %b", e.name, cyc, gate_en, e.val);
                end
            end else if (gate_en !== prev) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_change @cycle %0d: gate_en_o=%b expected %b (no change due)", cyc, gate_en, prev);
            end
            prev = gate_en;
        end
    end

    task automatic push(input int c, input logic [GN-1:0] v, input string n);
        exp_t x;
        x.cyc  = c;
        x.val  = v;
        x.name = n;
        exp_q.push_back(x);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reset sampled at the next edge; returns the first edge that sees reset released.
    task automatic pulse_reset(output int e1, input string n);
        rst_n = 1'b0;
        push(cyc + 1, '0, n);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        e1 = cyc + 1;
    endtask

    task automatic push_steps(input int g0, input int step, input int count, input string n);
        logic [GN-1:0] v;
        v = '0;
        for (int k = 0; k < count; k++) begin
            v[k] = 1'b1;
            push(g0 + k * step, v, n);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int e1, g0, c, r;
        logic [GN-1:0] v;
        loop_mode = 1'b0;
        sync_drv  = '0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        prev   = gate_en;
        mon_on = 1'b1;
        push(cyc, '0, "reset_state");

        // Scenario 1: loopback, full ordered sequence with identical step intervals
        loop_mode = 1'b1;
        pulse_reset(e1, "s1_reset");
        g0 = e1 + ID + 1;
        push_steps(g0, LOOP_STEP, GN, "s1_step");
        push(g0 + 4 * LOOP_STEP + 20, '1, "s1_hold");
        wait_until(g0 + 4 * LOOP_STEP + 21);

        // Scenario 5: sync dropped while in DONE
        loop_mode = 1'b0;
        sync_drv  = '0;
        c = cyc;
        push(c + 5, '1, "s5_done_hold");
        push(c + 15, '1, "s5_done_hold");
        wait_until(c + 16);

        // Scenario 4: reset pulse while three gates are enabled
        loop_mode = 1'b1;
        pulse_reset(e1, "s4_reset_from_done");
        g0 = e1 + ID + 1;
        push_steps(g0, LOOP_STEP, 3, "s4_step");
        wait_until(g0 + 2 * LOOP_STEP + 2);
        pulse_reset(e1, "s4_mid_reset");
        g0 = e1 + ID + 1;
        push_steps(g0, LOOP_STEP, GN, "s4_restart_step");
        wait_until(g0 + 4 * LOOP_STEP + 2);

        // Scenario 2: sync never arrives
        loop_mode = 1'b0;
        sync_drv  = '0;
        pulse_reset(e1, "s2_reset");
        g0 = e1 + ID + 1;
        push(g0, 5'b00001, "s2_first_enable");
`ifdef STARTUP_TIMEOUT_EN
        push(g0 + TO, '0, "s2_timeout_clear");
        push(g0 + TO + ID + 2, 5'b00001, "s2_reenable");
        wait_until(g0 + TO + ID + 4);
`else
        push(g0 + 40, 5'b00001, "s2_wait_hold");
        push(g0 + 80, 5'b00001, "s2_wait_hold");
        wait_until(g0 + 82);
`endif

        // Scenario 3: other gates' sync high from reset, bit 0 raised late
        sync_drv = 5'b11110;
        pulse_reset(e1, "s3_reset");
        g0 = e1 + ID + 1;
        push(g0, 5'b00001, "s3_first_enable");
        push(g0 + 20, 5'b00001, "s3_ignore_other_sync");
        wait_until(g0 + 20);
        r = cyc;
        sync_drv = '1;
        v = 5'b00001;
        for (int k = 1; k < GN; k++) begin
            v[k] = 1'b1;
            push(r + SD + 4 + (k - 1) * FAST_STEP, v, "s3_step");
        end
        wait_until(r + SD + 4 + (GN - 2) * FAST_STEP + 3);

        repeat (2) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL pending_expectations: %0d left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
